// File: rtl/bitwise_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// Optional saturating grant counters are enabled with BITWISE_ARB_STATS_EN.
module bitwise_unit_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e           state_q;
    logic             last_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] unit_out;
    logic             win_valid;
    logic             win_id;

    // On a tie the requester that did not win last time takes the unit.
    always_comb begin
        win_valid = req0 | req1;
        if (req0 && req1) begin
            win_id = ~last_q;
        end else begin
            win_id = req1;
        end
    end

    always_comb begin
        unit_out = '0;
        unique case (op_q)
            2'b00: unit_out = a_q & b_q;
            2'b01: unit_out = a_q | b_q;
            2'b10: unit_out = a_q ^ b_q;
            2'b11: unit_out = a_q & ~b_q;
            default: unit_out = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            result   <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (win_valid) begin
                        grant_id <= win_id;
                        op_q     <= win_id ? op1 : op0;
                        a_q      <= win_id ? a1 : a0;
                        b_q      <= win_id ? b1 : b0;
                        busy     <= 1'b1;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    result  <= unit_out;
                    last_q  <= grant_id;
                    done0   <= ~grant_id;
                    done1   <= grant_id;
                    state_q <= StDone;
                end
                StDone: begin
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef BITWISE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Counters saturate rather than wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state_q == StDone) begin
            if (!grant_id && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (grant_id && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed self-checking bench for bitwise_unit_arbiter.
// Expected counter values follow BITWISE_ARB_STATS_EN (CNT_W shrunk to 2 when enabled).
module tb_bitwise_unit_arbiter;

    localparam int unsigned WIDTH = 32;
`ifdef BITWISE_ARB_STATS_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 16;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req0 = 1'b0;
    logic [1:0]       op0 = 2'b00;
    logic [WIDTH-1:0] a0 = '0;
    logic [WIDTH-1:0] b0 = '0;
    logic             req1 = 1'b0;
    logic [1:0]       op1 = 2'b00;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] b1 = '0;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             grant_id;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int errors = 0;
    int checks = 0;

    bitwise_unit_arbiter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req0    (req0),
        .op0     (op0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .op1     (op1),
        .a1      (a1),
        .b1      (b1),
        .done0   (done0),
        .done1   (done1),
        .result  (result),
        .busy    (busy),
        .grant_id(grant_id),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({done0, done1, busy, grant_id} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {done0, done1, busy, grant_id});
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 00000000", result);
        end
        checks++;
        if (cnt0 !== '0 || cnt1 !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        req0 = 1'b1; op0 = 2'b00; a0 = 32'hF0F0_F0F0; b0 = 32'hFF00_FF00;
        @(negedge clock);
        checks++;
        if ({busy, done0, done1, grant_id} !== 4'b1000) begin
            errors++;
            $display("FAIL single_exec: got %b want 1000", {busy, done0, done1, grant_id});
        end
        @(negedge clock);
        checks++;
        if ({busy, done0, done1} !== 3'b110 || result !== 32'hF000_F000) begin
            errors++;
            $display("FAIL single_done: got %b %h want 110 f000f000", {busy, done0, done1},
                     result);
        end
        req0 = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done0, done1} !== 3'b000 || result !== 32'hF000_F000) begin
            errors++;
            $display("FAIL single_idle: got %b %h want 000 f000f000", {busy, done0, done1},
                     result);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req0 = 1'b1; op0 = 2'b01; a0 = 32'h0000_FFFF; b0 = 32'h00FF_0000;
        req1 = 1'b1; op1 = 2'b10; a1 = 32'hAAAA_AAAA; b1 = 32'hFFFF_FFFF;
        @(negedge clock);
        checks++;
        if (grant_id !== 1'b0) begin
            errors++;
            $display("FAIL sim_grant_first: got %b want 0", grant_id);
        end
        @(negedge clock);
        checks++;
        if ({done0, done1} !== 2'b10 || result !== 32'h00FF_FFFF) begin
            errors++;
            $display("FAIL sim_done0: got %b %h want 10 00ffffff", {done0, done1}, result);
        end
        req0 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (grant_id !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sim_grant_second: got %b/%b want 1/1", grant_id, busy);
        end
        @(negedge clock);
        checks++;
        if ({done0, done1} !== 2'b01 || result !== 32'h5555_5555) begin
            errors++;
            $display("FAIL sim_done1: got %b %h want 01 55555555", {done0, done1}, result);
        end
        req1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int last_cyc = 0;
        apply_reset();
        req0 = 1'b1; op0 = 2'b10; a0 = 32'h1; b0 = 32'h0;
        req1 = 1'b1; op1 = 2'b10; a1 = 32'h2; b1 = 32'h0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clock);
            if (done0 || done1) begin
                checks++;
                if ({done0, done1} !== ((n % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL b2b_order%0d: got %b want %b", n, {done0, done1},
                             (n % 2 == 0) ? 2'b10 : 2'b01);
                end
                checks++;
                if (result !== ((n % 2 == 0) ? 32'h1 : 32'h2)) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h want %h", n, result,
                             (n % 2 == 0) ? 32'h1 : 32'h2);
                end
                checks++;
                if (cyc - last_cyc !== ((n == 0) ? 2 : 3)) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d want %0d", n, cyc - last_cyc,
                             (n == 0) ? 2 : 3);
                end
                last_cyc = cyc;
                n++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 6", n);
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_operand_capture();
        apply_reset();
        req1 = 1'b1; op1 = 2'b11; a1 = 32'h1234_5678; b1 = 32'hFFFF_FFFF;
        @(negedge clock);
        op1 = 2'b01; a1 = 32'hFFFF_FFFF; b1 = 32'h0;
        checks++;
        if (grant_id !== 1'b1) begin
            errors++;
            $display("FAIL cap_grant: got %b want 1", grant_id);
        end
        @(negedge clock);
        checks++;
        if (done1 !== 1'b1 || result !== 32'h0) begin
            errors++;
            $display("FAIL cap_andn: got %b %h want 1 00000000", done1, result);
        end
        req1 = 1'b0;
        @(negedge clock);
        req0 = 1'b1; op0 = 2'b11; a0 = 32'hFFFF_0000; b0 = 32'h0F0F_0F0F;
        @(negedge clock);
        req0 = 1'b0;
        @(negedge clock);
        checks++;
        if (done0 !== 1'b1 || result !== 32'hF0F0_0000) begin
            errors++;
            $display("FAIL cap_andn2: got %b %h want 1 f0f00000", done0, result);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        req0 = 1'b1; op0 = 2'b01; a0 = 32'h0000_FFFF; b0 = 32'h0;
        @(negedge clock);
        @(negedge clock);
        req0 = 1'b0;
        checks++;
        if (result !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL rst_pre: got %h want 0000ffff", result);
        end
        @(negedge clock);
        req0 = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done0, done1} !== 3'b000 || result !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: got %b %h want 000 00000000", {busy, done0, done1}, result);
        end
        req0 = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done0, done1} !== 3'b000) begin
            errors++;
            $display("FAIL rst_hold: got %b want 000", {busy, done0, done1});
        end
        reset = 1'b1;
        req1 = 1'b1; op1 = 2'b00; a1 = 32'hFFFF_FFFF; b1 = 32'h0000_FFFF;
        @(negedge clock);
        checks++;
        if (grant_id !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_regrant: got %b/%b want 1/1", grant_id, busy);
        end
        @(negedge clock);
        checks++;
        if ({done0, done1} !== 2'b01 || result !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL rst_done1: got %b %h want 01 0000ffff", {done0, done1}, result);
        end
        req1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_counters();
        int n = 0;
        logic prev_done = 1'b0;
        logic [CNT_W-1:0] exp_cnt;
        apply_reset();
        req0 = 1'b1; op0 = 2'b00; a0 = 32'h1; b0 = 32'h1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clock);
            if (prev_done) begin
`ifdef BITWISE_ARB_STATS_EN
                exp_cnt = CNT_W'((n > 3) ? 3 : n);
`else
                exp_cnt = '0;
`endif
                checks++;
                if (cnt0 !== exp_cnt || cnt1 !== '0) begin
                    errors++;
                    $display("FAIL cnt_after%0d: got %0d/%0d want %0d/0", n, cnt0, cnt1,
                             exp_cnt);
                end
            end
            prev_done = done0;
            if (done0) begin
                n++;
                if (n == 5) req0 = 1'b0;
            end
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL cnt_grants: got %0d want 5", n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_operand_capture();
        test_reset_mid_op();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitwise_unit_arbiter.md
Name: bitwise_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/ANDN) between two requesters, e.g. the execute stage and the multdiv sequencer.
- Round-robin arbitration and operand capture feed a registered result, with a per-requester req/done handshake.
- Sits in the processor datapath beside the ALU. Owns the only instance of the bitwise unit.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; held high until done0.
- op0  in  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 ANDN (A & ~B).
- a0, b0  in  WIDTH  requester 0 operands.
- req1, op1, a1, b1  in  1/2/WIDTH/WIDTH  requester 1, same meaning.
- done0  out  1  one-cycle pulse: result belongs to requester 0.
- done1  out  1  one-cycle pulse: result belongs to requester 1.
- result  out  WIDTH  registered result, held until the next completion.
- busy  out  1  high while in EXEC or DONE.
- grant_id  out  1  requester currently owned (valid while busy).
- cnt0, cnt1  out  CNT_W  grant counters (only with the optional feature).

Behaviour:
- Reset (reset=0, asynchronous) forces the following, from any state, including mid-operation:
  - state=IDLE, result=0, done0=done1=0, busy=0, grant_id=0, last=1 (so requester 0 wins the first tie).
  - An in-flight op is dropped; no done pulse is issued.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester not equal to last.
  - On grant: latch op/a/b of the winner into internal registers, set grant_id, go to EXEC.
- EXEC:
  - Shared unit computes from the latched operands only; input changes in this cycle are ignored.
  - On the edge: result <= computed value, last <= grant_id, go to DONE.
- DONE:
  - done[grant_id]=1 for exactly this cycle; the other done stays 0.
  - Requests are not sampled. Next state is IDLE.
- Latency: req sampled high on edge N; done and result are valid during cycle N+2.
  - Issue rate is one op per 3 cycles.
- Requester must drop req in the cycle done is seen. If req is still high in the following IDLE cycle, it is treated as a new request.
- Both requesting continuously: grants strictly alternate 0,1,0,1...
- A req that rises while busy waits; it is sampled on the first IDLE cycle.
- busy = (state != IDLE). result keeps its last value through IDLE.
- ANDN with b=all-ones gives 0. Operations are purely bitwise; no carry or width extension.
- Unused state encoding recovers to IDLE on the next edge.

Optional Feature:
- Macro: BITWISE_ARB_STATS_EN.
- Defined:
  - cnt0/cnt1 increment on each DONE cycle for the owning requester.
  - Counters saturate at all-ones and never wrap.
  - Reset clears them to 0.
- Undefined: cnt0/cnt1 are driven constant 0 and no counter registers exist.

Test Plan:
- Reset, then req0=1, op0=00, a0=0xF0F0F0F0, b0=0xFF00FF00 -> done0 in cycle 2 after sample, result=0xF000F000, done1 stays 0, busy high for 2 cycles.
- Simultaneous req0 (op 01, a=0x0000FFFF, b=0x00FF0000) and req1 (op 10, a=0xAAAAAAAA, b=0xFFFFFFFF) held -> first done0 with result 0x00FFFFFF, then done1 with result 0x55555555; grant_id order 0,1.
- Both requesters held for 6 grants -> done sequence 0,1,0,1,0,1, each 3 cycles apart.
- req1 op=11, a=0x12345678, b=0xFFFFFFFF; change a1 during EXEC -> result=0x00000000, unaffected by the change.
- Assert reset during EXEC -> no done pulse, result=0, busy=0 immediately. Then req1 alone -> granted to requester 1.
- With BITWISE_ARB_STATS_EN and CNT_W forced to 2: five grants to requester 0 -> cnt0=3 (saturated), cnt1=0. Without the macro -> cnt0=cnt1=0 throughout.
